// File: rtl/tbu_ctrl.sv
// Traceback unit controller: counts ACS decision fills, picks the best start state,
// walks the decision memory newest-to-oldest and emits one decoded bit per traceback.
module tbu_ctrl #(
  parameter int unsigned TBL      = 15,
  parameter int unsigned PM_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  input  logic                    flush_i,
  input  logic [PM_WIDTH-1:0]     pm_s0_i,
  input  logic [PM_WIDTH-1:0]     pm_s1_i,
  input  logic [PM_WIDTH-1:0]     pm_s2_i,
  input  logic [PM_WIDTH-1:0]     pm_s3_i,
  input  logic [3:0]              rd_data_i,
  output logic                    pmu_valid_o,
  output logic [$clog2(TBL)-1:0]  rd_addr_o,
  output logic                    ready_o,
  output logic                    bit_o,
  output logic                    bit_valid_o,
  output logic                    drop_o
);

  localparam int unsigned AW = $clog2(TBL);
  localparam int unsigned FW = $clog2(TBL + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(TBL);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEL   = 2'd1;
  localparam logic [1:0] S_TRACE = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;

  logic [1:0]    r_state;
  logic [FW-1:0] r_fill;
  logic [1:0]    r_tb_state;
  logic [AW-1:0] r_rd_addr;
  logic          r_bit;
  logic          r_bit_valid;
  logic          r_drop;

  logic                w_ready;
  logic                w_accept;
  logic                w_fill_hit;
  logic                w_i01;
  logic                w_i23;
  logic                w_hi;
  logic [PM_WIDTH-1:0] w_m01;
  logic [PM_WIDTH-1:0] w_m23;
  logic [1:0]          w_min_idx;

  assign w_ready    = (r_state == S_IDLE);
  assign w_accept   = valid_i & w_ready;
  assign w_fill_hit = (r_fill >= FILL_MAX - FW'(1));

  // Strict less-than at each level keeps ties on the lower index.
  assign w_i01     = (pm_s1_i < pm_s0_i);
  assign w_m01     = w_i01 ? pm_s1_i : pm_s0_i;
  assign w_i23     = (pm_s3_i < pm_s2_i);
  assign w_m23     = w_i23 ? pm_s3_i : pm_s2_i;
  assign w_hi      = (w_m23 < w_m01);
  assign w_min_idx = w_hi ? {1'b1, w_i23} : {1'b0, w_i01};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_fill      <= '0;
      r_tb_state  <= 2'd0;
      r_rd_addr   <= '0;
      r_bit       <= 1'b0;
      r_bit_valid <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      if (flush_i) begin
        r_fill <= w_accept ? FW'(1) : '0;
      end else if (w_accept && (r_fill != FILL_MAX)) begin
        r_fill <= r_fill + FW'(1);
      end

      if (valid_i && !w_ready) r_drop <= 1'b1;

      r_bit_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && !flush_i && w_fill_hit) r_state <= S_SEL;
        end
        S_SEL: begin
          r_tb_state <= w_min_idx;
          r_rd_addr  <= AW'(TBL - 1);
          r_state    <= S_TRACE;
        end
        S_TRACE: begin
          r_tb_state <= {r_tb_state[0], rd_data_i[r_tb_state]};
          if (r_rd_addr != '0) begin
            r_rd_addr <= r_rd_addr - AW'(1);
          end else begin
            // Oldest step: the decoded bit is the MSB of the state before this update.
            r_bit       <= r_tb_state[1];
            r_bit_valid <= 1'b1;
            r_rd_addr   <= '0;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pmu_valid_o = w_accept;
  assign ready_o     = w_ready;
  assign rd_addr_o   = r_rd_addr;
  assign bit_o       = r_bit;
  assign bit_valid_o = r_bit_valid;
  assign drop_o      = r_drop;

endmodule

// File: tb/tb_tbu_ctrl.sv
// Bench for tbu_ctrl: cycle-level reference model compared every negedge,
// plus directed scenarios with literal expectations.
module tb_tbu_ctrl;

  localparam int TBL = 15;
  localparam int PMW = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           valid_i = 1'b0;
  logic           flush_i = 1'b0;
  logic [PMW-1:0] pm_s0_i = 8'd10;
  logic [PMW-1:0] pm_s1_i = 8'd10;
  logic [PMW-1:0] pm_s2_i = 8'd10;
  logic [PMW-1:0] pm_s3_i = 8'd10;
  logic [3:0]     rd_data_i;
  logic           pmu_valid_o;
  logic [3:0]     rd_addr_o;
  logic           ready_o;
  logic           bit_o;
  logic           bit_valid_o;
  logic           drop_o;

  logic [3:0] dmem [TBL];

  int n_vec = 0;
  int n_err = 0;

  tbu_ctrl #(
    .TBL      (TBL),
    .PM_WIDTH (PMW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .flush_i     (flush_i),
    .pm_s0_i     (pm_s0_i),
    .pm_s1_i     (pm_s1_i),
    .pm_s2_i     (pm_s2_i),
    .pm_s3_i     (pm_s3_i),
    .rd_data_i   (rd_data_i),
    .pmu_valid_o (pmu_valid_o),
    .rd_addr_o   (rd_addr_o),
    .ready_o     (ready_o),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o),
    .drop_o      (drop_o)
  );

  always #5 clk = ~clk;

  // Decision memory model: combinational read at the DUT's address.
  assign rd_data_i = (int'(rd_addr_o) < TBL) ? dmem[rd_addr_o] : 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_dmem(input logic [3:0] v);
    for (int i = 0; i < TBL; i++) dmem[i] = v;
  endtask

  function automatic int argmin_pm();
    int idx = 0;
    int pm [4];
    pm[0] = int'(pm_s0_i); pm[1] = int'(pm_s1_i);
    pm[2] = int'(pm_s2_i); pm[3] = int'(pm_s3_i);
    for (int i = 1; i < 4; i++) if (pm[i] < pm[idx]) idx = i;
    return idx;
  endfunction

  // Walk from the best state through addresses TBL-1 down to 1; bit is the MSB reached.
  function automatic logic trace_bit();
    int s = argmin_pm();
    for (int a = TBL - 1; a >= 1; a--) s = ((s & 1) << 1) | int'(dmem[a][s]);
    return logic'((s >> 1) & 1);
  endfunction

  // Reference model: m_c counts cycles since the triggering edge (0 = idle).
  int   m_fill = 0;
  int   m_c = 0;
  logic m_bit = 1'b0;
  logic m_drop = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fill <= 0;
      m_c    <= 0;
      m_bit  <= 1'b0;
      m_drop <= 1'b0;
    end else begin
      if (valid_i && m_c == 0) begin
        if (flush_i) m_fill <= 1;
        else begin
          if (m_fill + 1 >= TBL) m_c <= 1;
          m_fill <= (m_fill + 1 > TBL) ? TBL : m_fill + 1;
        end
      end else if (flush_i) begin
        m_fill <= 0;
      end
      if (valid_i && m_c != 0) m_drop <= 1'b1;
      if (m_c != 0) m_c <= (m_c == TBL + 2) ? 0 : m_c + 1;
      if (m_c == TBL + 1) m_bit <= trace_bit();
    end
  end

  always @(negedge clk) begin
    int exp_addr;
    exp_addr = (m_c >= 2 && m_c <= TBL + 1) ? TBL + 1 - m_c : 0;
    chk("model_ready", 32'(ready_o), 32'(m_c == 0));
    chk("model_bit_valid", 32'(bit_valid_o), 32'(m_c == TBL + 2));
    chk("model_rd_addr", 32'(rd_addr_o), 32'(exp_addr));
    chk("model_bit", 32'(bit_o), 32'(m_bit));
    chk("model_drop", 32'(drop_o), 32'(m_drop));
    chk("model_pmu_valid", 32'(pmu_valid_o), 32'(valid_i && m_c == 0));
  end

  task automatic cyc(input logic v, input logic f);
    valid_i = v;
    flush_i = f;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!ready_o && k < 3 * TBL) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("wait_idle", 32'(ready_o), 32'd1);
  endtask

  initial begin
    int   k;
    logic seen;
    fill_dmem(4'hF);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_bit_valid", 32'(bit_valid_o), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    chk("rst_bit", 32'(bit_o), 32'd0);
    chk("rst_drop", 32'(drop_o), 32'd0);
    rst_n = 1'b1;

    // Fill: TBL-1 accepted keep ready, the TBL-th triggers; all-ones decisions, tied PMs.
    repeat (TBL - 1) cyc(1'b1, 1'b0);
    chk("fill_ready_hold", 32'(ready_o), 32'd1);
    cyc(1'b1, 1'b0);
    chk("fill_ready_low", 32'(ready_o), 32'd0);
    k = 0;
    while (!bit_valid_o && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("fill_bv_latency", 32'(k), 32'(TBL + 1));
    chk("ones_bit", 32'(bit_o), 32'd1);
    @(posedge clk);
    #1;
    chk("fill_ready_back", 32'(ready_o), 32'd1);
    chk("fill_bv_one_cycle", 32'(bit_valid_o), 32'd0);

    // Minimum selection with all-zero decisions.
    pm_s2_i = 8'd3;
    fill_dmem(4'h0);
    cyc(1'b1, 1'b0);
    for (int j = 0; j < TBL; j++) begin
      @(posedge clk);
      #1;
      chk("min_rd_addr_seq", 32'(rd_addr_o), 32'(TBL - 1 - j));
    end
    @(posedge clk);
    #1;
    chk("min_bit_valid", 32'(bit_valid_o), 32'd1);
    chk("min_bit", 32'(bit_o), 32'd0);
    @(posedge clk);
    #1;
    chk("min_ready_back", 32'(ready_o), 32'd1);

    // Drop: valid during TRACE is ignored and flagged.
    cyc(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    valid_i = 1'b1;
    #1;
    chk("drop_pmu_valid", 32'(pmu_valid_o), 32'd0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk("drop_set", 32'(drop_o), 32'd1);
    wait_idle();
    chk("drop_sticky", 32'(drop_o), 32'd1);

    // Flush with valid: count restarts at 1, TBL-1 more needed.
    pm_s2_i = 8'd10;
    fill_dmem(4'hF);
    cyc(1'b1, 1'b1);
    chk("flush_no_trace", 32'(ready_o), 32'd1);
    repeat (TBL - 2) cyc(1'b1, 1'b0);
    chk("flush_refill_hold", 32'(ready_o), 32'd1);
    cyc(1'b1, 1'b0);
    chk("flush_refill_trig", 32'(ready_o), 32'd0);
    wait_idle();
    chk("flush_bit", 32'(bit_o), 32'd1);

    // Reset in the middle of a traceback.
    cyc(1'b1, 1'b0);
    k = 0;
    while (rd_addr_o != 4'd7 && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("midtrace_addr7", 32'(rd_addr_o), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready_o), 32'd1);
    chk("midrst_bit_valid", 32'(bit_valid_o), 32'd0);
    chk("midrst_rd_addr", 32'(rd_addr_o), 32'd0);
    chk("midrst_bit", 32'(bit_o), 32'd0);
    chk("midrst_drop", 32'(drop_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (TBL + 4) begin
      @(posedge clk);
      #1;
      if (bit_valid_o) seen = 1'b1;
    end
    chk("midrst_no_bv", 32'(seen), 32'd0);
    repeat (TBL - 1) cyc(1'b1, 1'b0);
    chk("midrst_refill_hold", 32'(ready_o), 32'd1);
    cyc(1'b1, 1'b0);
    chk("midrst_refill_trig", 32'(ready_o), 32'd0);
    wait_idle();
    chk("midrst_final_bit", 32'(bit_o), 32'd1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
